instr_decode_stage: RTL and testbench

//  Registered MIPS-32 decode stage: accepts {pc, instr} from IF over valid/ready, splits fields
//  (rs/rt/rd/shamt/funct/opcode/imm/index), extends immediate, computes J-target and reg-use flags.

---
 rtl/cpu_isa_pkg.sv | 46 ++++
 rtl/instr_field_split.sv | 90 +++++++++
 rtl/instr_decode_stage.sv | 148 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// MIPS-32 ISA constants and the decoded-field payload shared by the decode stage.
package cpu_isa_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR    = 6'h08;

  // Decoded fields and register-use flags (width-independent part of the payload)
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [OP_W-1:0]  funct;
    logic             uses_rs;
    logic             uses_rt;
    logic             wr_en;
    logic [REG_W-1:0] wr_addr;
  } dec_fields_t;

  // Logical immediates are zero-extended
  function automatic logic is_zext_op(input logic [OP_W-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational MIPS-32 field split, immediate extension, jump target and
// register-use flags.
// Ports:
//   pc, instr      : pc and raw instruction being decoded
//   fields_c       : opcode/rs/rt/rd/shamt/funct plus uses_rs/uses_rt/wr_en/wr_addr
//   imm_ext_c      : extended immediate (DATA_W)
//   j_target_c     : {pc+4[PC_W-1:28], instr[25:0], 2'b00}
module instr_field_split
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RA_REG = 31
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields_c,
  output logic [DATA_W-1:0]  imm_ext_c,
  output logic [PC_W-1:0]    j_target_c
);

  // Bits of the jump target supplied by the instruction; the rest come from pc+4
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(32'h0FFF_FFFF);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc_plus4;
  logic             wr_req;
  logic [REG_W-1:0] dest;

  assign op       = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm      = instr[15:0];
  assign pc_plus4 = pc + PC_W'(4);

  // Immediate extension
  always_comb begin
    imm_ext_c = DATA_W'($signed(imm));
    if (is_zext_op(op)) begin
      imm_ext_c = DATA_W'(imm);
    end else if (op == OP_LUI) begin
      imm_ext_c = DATA_W'($signed({imm, 16'h0000}));
    end
  end

  // Pseudo-direct jump target, upper bits from the wrapped pc+4
  assign j_target_c = (pc_plus4 & ~LOW_MASK) | PC_W'({instr[25:0], 2'b00});

  // Destination register selection and write request
  always_comb begin
    wr_req = 1'b0;
    dest   = rt;
    case (op)
      OP_RTYPE: begin
        wr_req = (instr[5:0] != FN_JR);
        dest   = rd;
      end
      OP_JAL: begin
        wr_req = 1'b1;
        dest   = REG_W'(RA_REG);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        wr_req = 1'b1;
      end
      default: begin
        wr_req = 1'b0;
      end
    endcase
  end

  // Field packing; writes to $0 are suppressed
  always_comb begin
    fields_c         = '0;
    fields_c.opcode  = op;
    fields_c.rs      = instr[25:21];
    fields_c.rt      = rt;
    fields_c.rd      = rd;
    fields_c.shamt   = instr[10:6];
    fields_c.funct   = instr[5:0];
    fields_c.uses_rs = !(op inside {OP_J, OP_JAL, OP_LUI});
    fields_c.uses_rt = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    fields_c.wr_addr = dest;
    fields_c.wr_en   = wr_req && (dest != '0);
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered MIPS-32 decode stage between fetch and the ID/EX register.
// Accepts {in_pc, in_instr} over in_valid/in_ready, presents the decoded
// instruction on out_* over out_valid/out_ready with one cycle of latency.
// flush squashes every held instruction at the next edge.
// Build option: define ID_SKID_EN for a 1-entry skid buffer (registered
// in_ready, full throughput under backpressure); otherwise in_ready is
// out_ready || !out_valid.
// Ports:
//   clk, rst_n, flush                    : clock, async active-low reset, squash
//   in_valid/in_ready/in_pc/in_instr     : fetch side
//   out_valid/out_ready/out_pc           : EX side handshake and pc
//   opcode/funct/rs/rt/rd/shamt          : instruction fields
//   imm_ext/j_target                     : extended immediate, jump target
//   uses_rs/uses_rt/wr_en/wr_addr        : hazard/writeback information
module instr_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RA_REG = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [OP_W-1:0]    opcode,
  output logic [OP_W-1:0]    funct,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   shamt,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [PC_W-1:0]    j_target,
  output logic               uses_rs,
  output logic               uses_rt,
  output logic               wr_en,
  output logic [REG_W-1:0]   wr_addr
);

  logic               accept;
  logic               load_c;
  logic [PC_W-1:0]    src_pc;
  logic [INSTR_W-1:0] src_instr;

  dec_fields_t        dec_c;
  logic [DATA_W-1:0]  dec_imm_c;
  logic [PC_W-1:0]    dec_jt_c;

  logic               out_valid_q;
  logic [PC_W-1:0]    out_pc_q;
  dec_fields_t        fields_q;
  logic [DATA_W-1:0]  imm_q;
  logic [PC_W-1:0]    jt_q;

  assign accept = in_valid && in_ready;

`ifdef ID_SKID_EN
  logic               out_adv;
  logic               skid_valid_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  // Output register may take a new instruction this cycle
  assign out_adv   = !out_valid_q || out_ready;
  assign in_ready  = !skid_valid_q;
  // Skid contents are older than anything on the input, so they go first
  assign src_pc    = skid_valid_q ? skid_pc_q    : in_pc;
  assign src_instr = skid_valid_q ? skid_instr_q : in_instr;
  assign load_c    = out_adv && (skid_valid_q || accept);

  // Skid buffer: captures an accept while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (out_adv) begin
      skid_valid_q <= 1'b0;
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_pc_q    <= in_pc;
      skid_instr_q <= in_instr;
    end
  end
`else
  assign in_ready  = out_ready || !out_valid_q;
  assign src_pc    = in_pc;
  assign src_instr = in_instr;
  assign load_c    = accept;
`endif

  instr_field_split #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .RA_REG (RA_REG)
  ) u_split (
    .pc         (src_pc),
    .instr      (src_instr),
    .fields_c   (dec_c),
    .imm_ext_c  (dec_imm_c),
    .j_target_c (dec_jt_c)
  );

  // Output register; data holds while stalled or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      fields_q    <= '0;
      imm_q       <= '0;
      jt_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= src_pc;
      fields_q    <= dec_c;
      imm_q       <= dec_imm_c;
      jt_q        <= dec_jt_c;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign opcode    = fields_q.opcode;
  assign funct     = fields_q.funct;
  assign rs        = fields_q.rs;
  assign rt        = fields_q.rt;
  assign rd        = fields_q.rd;
  assign shamt     = fields_q.shamt;
  assign imm_ext   = imm_q;
  assign j_target  = jt_q;
  assign uses_rs   = fields_q.uses_rs;
  assign uses_rt   = fields_q.uses_rt;
  assign wr_en     = fields_q.wr_en;
  assign wr_addr   = fields_q.wr_addr;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage (default parameters); works with
// and without ID_SKID_EN defined.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, j_target;
  logic        uses_rs, uses_rt, wr_en;
  logic [4:0]  wr_addr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [31:0] jt;
    logic        uses_rs, uses_rt, wr_en;
    logic [4:0]  wr_addr;
  } obs_t;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm_ext(imm_ext), .j_target(j_target), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode from the ISA rules
  function automatic obs_t model(input logic [31:0] pc, input logic [31:0] instr);
    obs_t        e;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [31:0] pc4;
    logic [4:0]  dest;
    logic        w;
    op  = instr[31:26];
    imm = instr[15:0];
    e = '0;
    e.pc = pc; e.opcode = op; e.funct = instr[5:0];
    e.rs = instr[25:21]; e.rt = instr[20:16]; e.rd = instr[15:11]; e.shamt = instr[10:6];
    if (op >= 6'h0C && op <= 6'h0E) e.imm = {16'h0000, imm};
    else if (op == 6'h0F)           e.imm = {imm, 16'h0000};
    else                            e.imm = {{16{imm[15]}}, imm};
    pc4  = pc + 32'd4;
    e.jt = {pc4[31:28], instr[25:0], 2'b00};
    if (op == 6'h00) begin
      dest = instr[15:11]; w = (instr[5:0] != 6'h08);
    end else if (op == 6'h03) begin
      dest = 5'd31; w = 1'b1;
    end else begin
      dest = instr[20:16]; w = (op >= 6'h08 && op <= 6'h0F) || (op == 6'h23);
    end
    e.wr_addr = dest;
    e.wr_en   = w && (dest != 5'd0);
    e.uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
    e.uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    return e;
  endfunction

  function automatic obs_t actual();
    obs_t a;
    a.pc = out_pc; a.opcode = opcode; a.funct = funct;
    a.rs = rs; a.rt = rt; a.rd = rd; a.shamt = shamt;
    a.imm = imm_ext; a.jt = j_target;
    a.uses_rs = uses_rs; a.uses_rt = uses_rt; a.wr_en = wr_en; a.wr_addr = wr_addr;
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [16];
    logic [31:0] r;
    logic [5:0]  op;
    int          k;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
    r = $urandom();
    k = $urandom_range(0, 17);
    if (k < 16) op = ops[k];
    else        op = 6'($urandom_range(0, 63));
    if (op == 6'h00 && $urandom_range(0, 3) == 0) r[5:0] = 6'h08;
    if ($urandom_range(0, 7) == 0) r[20:16] = 5'd0;
    return {op, r[25:0]};
  endfunction

  // Present one instruction with out_ready=1 until accepted; returns at the
  // following negedge with in_valid dropped
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    int n;
    n = 0;
    in_valid = 1'b1; in_pc = pc; in_instr = instr; out_ready = 1'b1;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (actual() !== obs_t'(0)) begin errors++; $display("FAIL reset_data got=%h exp=0", actual()); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_jal();
    issue(32'h0000_3000, 32'h0C00_0C01); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL jal_valid got=%b exp=1", out_valid); end
    checks++; if (opcode !== 6'h03) begin errors++; $display("FAIL jal_opcode got=%h exp=03", opcode); end
    checks++; if (j_target !== 32'h0000_3004) begin errors++; $display("FAIL jal_target got=%h exp=00003004", j_target); end
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd31) begin errors++; $display("FAIL jal_wr got=%b/%0d exp=1/31", wr_en, wr_addr); end
    checks++; if (uses_rs !== 1'b0 || uses_rt !== 1'b0) begin errors++; $display("FAIL jal_uses got=%b%b exp=00", uses_rs, uses_rt); end
  endtask

  task automatic test_imm();
    issue(32'h0000_4000, 32'h3401_FFFF); #1;
    checks++; if (imm_ext !== 32'h0000_FFFF) begin errors++; $display("FAIL ori_imm got=%h exp=0000ffff", imm_ext); end
    issue(32'h0000_4004, 32'h2401_FFFF); #1;
    checks++; if (imm_ext !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addiu_imm got=%h exp=ffffffff", imm_ext); end
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd1) begin errors++; $display("FAIL addiu_wr got=%b/%0d exp=1/1", wr_en, wr_addr); end
    issue(32'h0000_4008, 32'h3C02_1234); #1;
    checks++; if (imm_ext !== 32'h1234_0000) begin errors++; $display("FAIL lui_imm got=%h exp=12340000", imm_ext); end
    checks++; if (uses_rs !== 1'b0 || wr_addr !== 5'd2 || wr_en !== 1'b1) begin errors++; $display("FAIL lui_flags got=%b/%0d/%b exp=0/2/1", uses_rs, wr_addr, wr_en); end
  endtask

  task automatic test_rtype();
    issue(32'h0000_5000, 32'h0022_1821); #1;
    checks++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3) begin errors++; $display("FAIL addu_regs got=%0d/%0d/%0d exp=1/2/3", rs, rt, rd); end
    checks++; if (wr_addr !== 5'd3 || wr_en !== 1'b1) begin errors++; $display("FAIL addu_wr got=%0d/%b exp=3/1", wr_addr, wr_en); end
    checks++; if (uses_rs !== 1'b1 || uses_rt !== 1'b1) begin errors++; $display("FAIL addu_uses got=%b%b exp=11", uses_rs, uses_rt); end
    checks++; if (funct !== 6'h21) begin errors++; $display("FAIL addu_funct got=%h exp=21", funct); end
    issue(32'h0000_5004, 32'h0020_0008); #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL jr_wr_en got=%b exp=0", wr_en); end
    checks++; if (uses_rs !== 1'b1) begin errors++; $display("FAIL jr_uses_rs got=%b exp=1", uses_rs); end
    issue(32'h0000_5008, 32'h2400_0005); #1;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin errors++; $display("FAIL zero_dest got=%b/%0d exp=0/0", wr_en, wr_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    obs_t q[$];
    obs_t e;
    int sent, got;
    pcs = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    for (int i = 0; i < 3; i++) ins[i] = rand_instr();
    sent = 0; got = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (sent < 3);
      if (sent < 3) begin in_pc = pcs[sent]; in_instr = ins[sent]; end
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== pcs[0]) begin
          errors++; $display("FAIL stall_hold cyc%0d got=%b/%h exp=1/%h", cyc, out_valid, out_pc, pcs[0]);
        end
      end
`ifdef ID_SKID_EN
      if (cyc == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_accept got=%b exp=1", in_ready); end
      end
`endif
      if (cyc == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got pc=%h exp=none", out_pc);
        end else begin
          e = q.pop_front(); got++;
          if (actual() !== e) begin errors++; $display("FAIL b2b_order got=%h exp=%h", actual(), e); end
        end
      end
      if (in_valid && in_ready) begin q.push_back(model(in_pc, in_instr)); sent++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got != 3 || q.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d left=%0d exp=3/0", got, q.size()); end
  endtask

  task automatic test_flush();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0000_0200; in_instr = rand_instr();
    @(negedge clk);
    in_pc = 32'h0000_0204; in_instr = rand_instr();
    @(negedge clk);
    flush = 1'b1; in_pc = 32'h0000_0208; in_instr = rand_instr();
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got=%b/%b exp=0/1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cyc%0d got pc=%h exp=no output", i, out_pc); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0000_0300; in_instr = rand_instr();
    @(negedge clk);
    in_pc = 32'h0000_0304; in_instr = rand_instr();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got=%b/%b exp=0/1", in_ready, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_leak cyc%0d got pc=%h exp=no output", i, out_pc); end
    end
    @(negedge clk);
  endtask

  task automatic test_pc_wrap();
    issue(32'hFFFF_FFFC, 32'h0C00_0C01); #1;
    checks++; if (j_target !== 32'h0000_3004) begin errors++; $display("FAIL wrap_target got=%h exp=00003004", j_target); end
    checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", out_pc); end
  endtask

  task automatic test_random();
    obs_t q[$];
    obs_t e, held, act;
    logic stall_prev, fl;
    logic [31:0] r;
    stall_prev = 1'b0; held = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      fl = ($urandom_range(0, 99) < 3);
      flush     = fl;
      out_ready = fl ? 1'b0 : ($urandom_range(0, 99) < 60);
      in_valid  = ($urandom_range(0, 99) < 70);
      r = $urandom();
      in_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
      in_instr = rand_instr();
      #1;
      act = actual();
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || act !== held) begin
          errors++; $display("FAIL rand_stable cyc%0d got=%b/%h exp=1/%h", cyc, out_valid, act, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra cyc%0d got=%h exp=none", cyc, act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin errors++; $display("FAIL rand_data cyc%0d got=%h exp=%h", cyc, act, e); end
        end
      end
      if (fl) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_pc, in_instr));
      stall_prev = out_valid && !out_ready && !fl;
      held = act;
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL drain_extra got=%h exp=none", actual());
        end else begin
          e = q.pop_front();
          if (actual() !== e) begin errors++; $display("FAIL drain_data got=%h exp=%h", actual(), e); end
        end
      end
      @(negedge clk);
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost left=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_imm();
    test_rtype();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
